lector_mascara: RTL

//  Fetches mask coefficients after the instruction interface latches mask start address and size.

---
 rtl/lector_mascara.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lector_mascara.sv
// Mask coefficient reader: fetches ceil(N*N/4) words from on-chip port 2 and unpacks them
// LSB-first into 8-bit coefficients. Optional running sum behind LECTOR_MASCARA_SUMA_EN.
module lector_mascara #(
  parameter int unsigned BITS_MEMORY_DATA     = 32,
  parameter int unsigned BITS_ADDR_MEM_ONCHIP = 14,
  parameter int unsigned BITS_COEF            = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            iniciar,
  input  logic [BITS_ADDR_MEM_ONCHIP-1:0] direccion_inicio_mascara,
  input  logic [2:0]                      tamano_mascara,
  input  logic                            op_complete_mem_onchip_port_2,
  input  logic [BITS_MEMORY_DATA-1:0]     data_mem_onchip_port_2,
  output logic                            read_mem_onchip_port_2,
  output logic [BITS_ADDR_MEM_ONCHIP-1:0] address_mem_onchip_port_2,
  output logic                            coef_valido,
  output logic [BITS_COEF-1:0]            coef_dato,
  output logic [5:0]                      coef_indice,
  output logic                            mascara_lista,
  output logic                            error_tamano,
`ifdef LECTOR_MASCARA_SUMA_EN
  output logic [BITS_COEF+6-1:0]          suma_coeficientes,
`endif
  output logic                            ocupado
);

  typedef enum logic [1:0] {StReposo, StLeer, StDesempacar, StListo} state_t;

  state_t                          state_q, state_d;
  logic [BITS_ADDR_MEM_ONCHIP-1:0] addr_q, addr_d;
  logic [5:0]                      total_q, total_d;
  logic [5:0]                      cnt_q, cnt_d;
  logic [1:0]                      lane_q, lane_d;
  logic [BITS_MEMORY_DATA-1:0]     word_q, word_d;
  logic [BITS_COEF-1:0]            dato_q, dato_d;
  logic [5:0]                      indice_q, indice_d;
  logic                            error_q, error_d;
  logic [BITS_COEF-1:0]            lane_coef;
  logic [5:0]                      tam6;
  logic                            acepta;

  assign tam6      = {3'b000, tamano_mascara};
  assign lane_coef = word_q[lane_q*BITS_COEF +: BITS_COEF];
  assign acepta    = (state_q == StReposo) && iniciar && (tamano_mascara != 3'd0);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    total_d  = total_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    word_d   = word_q;
    dato_d   = dato_q;
    indice_d = indice_q;
    error_d  = 1'b0;
    read_mem_onchip_port_2 = 1'b0;
    coef_valido            = 1'b0;
    mascara_lista          = 1'b0;
    unique case (state_q)
      StReposo: begin
        if (iniciar) begin
          if (tamano_mascara == 3'd0) begin
            error_d = 1'b1;
          end else begin
            addr_d  = direccion_inicio_mascara;
            total_d = tam6 * tam6;
            cnt_d   = '0;
            lane_d  = '0;
            state_d = StLeer;
          end
        end
      end
      StLeer: begin
        read_mem_onchip_port_2 = 1'b1;
        if (op_complete_mem_onchip_port_2) begin
          word_d  = data_mem_onchip_port_2;
          lane_d  = '0;
          state_d = StDesempacar;
        end
      end
      StDesempacar: begin
        coef_valido = 1'b1;
        dato_d      = lane_coef;
        indice_d    = cnt_q;
        cnt_d       = cnt_q + 6'd1;
        lane_d      = lane_q + 2'd1;
        // Mask end can fall mid-word; otherwise refetch only after lane 3.
        if (cnt_q + 6'd1 == total_q) begin
          state_d = StListo;
        end else if (lane_q == 2'd3) begin
          addr_d  = addr_q + 1'b1;
          state_d = StLeer;
        end
      end
      StListo: begin
        mascara_lista = 1'b1;
        state_d       = StReposo;
      end
      default: state_d = StReposo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StReposo;
      addr_q   <= '0;
      total_q  <= '0;
      cnt_q    <= '0;
      lane_q   <= '0;
      word_q   <= '0;
      dato_q   <= '0;
      indice_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      total_q  <= total_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
      dato_q   <= dato_d;
      indice_q <= indice_d;
      error_q  <= error_d;
    end
  end

  // Coefficient outputs show the live lane while valid and hold the last emitted value otherwise.
  assign coef_dato                 = coef_valido ? lane_coef : dato_q;
  assign coef_indice               = coef_valido ? cnt_q : indice_q;
  assign address_mem_onchip_port_2 = addr_q;
  assign error_tamano              = error_q;
  assign ocupado                   = (state_q != StReposo);

`ifdef LECTOR_MASCARA_SUMA_EN
  logic [BITS_COEF+6-1:0] suma_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      suma_q <= '0;
    end else if (acepta) begin
      suma_q <= '0;
    end else if (coef_valido) begin
      suma_q <= suma_q + {6'd0, lane_coef};
    end
  end

  assign suma_coeficientes = suma_q;
`else
  logic unused_acepta;
  assign unused_acepta = acepta;
`endif

endmodule
